// File: rtl/gate_net_pipe.sv
// Selectable 3-input gate network with a DEPTH-stage valid/ready pipeline,
// popcount of the result and a saturating delivered-beat counter.
module gate_net_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [WIDTH-1:0]           c,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           e,
  output logic [$clog2(WIDTH+1)-1:0] ones,
  input  logic                       clr,
  output logic [CNTW-1:0]            xfer_cnt
);

  localparam int OW = $clog2(WIDTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] e_q [DEPTH];
  logic [OW-1:0]    o_q [DEPTH];

  logic [WIDTH-1:0] d_n;
  logic [OW-1:0]    o_n;

  // Stage i can take data if any stage at or after it is empty.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign rdy[g] = out_ready | ~(&v[DEPTH-1:g]);
  end

  always_comb begin
    d_n = '0;
    unique case (mode)
      2'b00: d_n = (a & b) ^ ~c;
      2'b01: d_n = (a | b) ^ ~c;
      2'b10: d_n = (a & b) ^ c;
      2'b11: d_n = a ^ b ^ c;
    endcase
  end

  always_comb begin
    o_n = '0;
    for (int i = 0; i < WIDTH; i++)
      o_n = o_n + OW'(d_n[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
        e_q[i] <= '0;
        o_q[i] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          d_q[0] <= d_n;
          e_q[0] <= ~c;
          o_q[0] <= o_n;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d_q[i] <= d_q[i-1];
            e_q[i] <= e_q[i-1];
            o_q[i] <= o_q[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xfer_cnt <= '0;
    else if (clr)
      xfer_cnt <= '0;
    else if (out_valid && out_ready && !(&xfer_cnt))
      xfer_cnt <= xfer_cnt + 1'b1;
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign d         = d_q[DEPTH-1];
  assign e         = e_q[DEPTH-1];
  assign ones      = o_q[DEPTH-1];

endmodule
